// File: rtl/uart_tx_arb_pkg.sv
// Shared types for the UART TX arbiter: FSM state encoding and requester limits.
package uart_tx_arb_pkg;

  localparam int unsigned MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    HOLD  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               any,
  output logic [ID_W-1:0]    idx
);

  logic [ID_W-1:0] cand;

  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((32'(rr_ptr) + i) % NUM_REQ);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Packet lock (grant held until req_last) is built only with UART_TX_ARB_PKT_LOCK_EN.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   ack,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 trmt,
  output logic [7:0]           tx_data,
  input  logic                 tx_done
);

  localparam logic [NUM_REQ-1:0] ACK_ONE = NUM_REQ'(1);

  arb_state_t      state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] ptr_next;
  logic            last_q;
  logic            guard;
  logic            pick_any;
  logic [ID_W-1:0] pick_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  function automatic logic [7:0] lane(input logic [ID_W-1:0] sel);
    return req_data[8*sel +: 8];
  endfunction

  assign ptr_next = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;

`ifndef UART_TX_ARB_PKT_LOCK_EN
  logic unused_last;
  assign unused_last = last_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      trmt     <= 1'b0;
      ack      <= '0;
      busy     <= 1'b0;
      tx_data  <= 8'h00;
      grant_id <= '0;
      rr_ptr   <= '0;
      last_q   <= 1'b0;
      guard    <= 1'b0;
    end else begin
      trmt <= 1'b0;
      ack  <= '0;
      case (state)
        IDLE: begin
          if (pick_any && tx_done) begin
            grant_id <= pick_idx;
            tx_data  <= lane(pick_idx);
            last_q   <= req_last[pick_idx];
            trmt     <= 1'b1;
            ack      <= ACK_ONE << pick_idx;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          guard <= 1'b1;
          state <= BUSY;
        end
        BUSY: begin
          // tx_done in the first BUSY cycle still reflects the idle transmitter
          if (guard) begin
            guard <= 1'b0;
          end else if (tx_done) begin
`ifdef UART_TX_ARB_PKT_LOCK_EN
            if (!last_q) begin
              state <= HOLD;
            end else begin
              rr_ptr <= ptr_next;
              busy   <= 1'b0;
              state  <= IDLE;
            end
`else
            rr_ptr <= ptr_next;
            busy   <= 1'b0;
            state  <= IDLE;
`endif
          end
        end
`ifdef UART_TX_ARB_PKT_LOCK_EN
        HOLD: begin
          if (req[grant_id] && tx_done) begin
            tx_data <= lane(grant_id);
            last_q  <= req_last[grant_id];
            trmt    <= 1'b1;
            ack     <= ACK_ONE << grant_id;
            state   <= ISSUE;
          end
        end
`endif
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NUM_REQ=4) with a scoreboard of expected grants.
module tb_uart_tx_arbiter;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        busy;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;

  logic model_en;
  logic man_done;
  logic mdone = 1'b1;
  int   mcnt  = 0;
  int   cyc   = 0;

  assign tx_done = model_en ? mdone : man_done;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .req_last (req_last),
    .ack      (ack),
    .grant_id (grant_id),
    .busy     (busy),
    .trmt     (trmt),
    .tx_data  (tx_data),
    .tx_done  (tx_done)
  );

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    logic [7:0] base;
    logic [1:0] exp_id;
    logic [1:0] exp_ptr;
  } row_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic expect_grant(input logic [1:0] id, input logic [7:0] d);
    exp_t e;
    e.id   = id;
    e.data = d;
    sbq.push_back(e);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, busy}, 32'd0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: tx_done drops for L cycles after each trmt, then idles high
  always @(posedge clk) begin
    if (trmt) begin
      mcnt  <= L;
      mdone <= 1'b0;
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) mdone <= 1'b1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && trmt === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_trmt", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("sb_grant_id", {30'd0, grant_id}, {30'd0, e.id});
        chk("sb_tx_data", {24'd0, tx_data}, {24'd0, e.data});
        chk("sb_ack", {28'd0, ack}, {28'd0, 4'b0001 << e.id});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t rows[7];
    int   tcount;
    int   n;
    int   i0;
    int   i1;
    int   ackcnt[4];
    int   tt[5];
    logic bad;

    rows[0] = '{4'b1001, 8'h10, 2'd3, 2'd0};
    rows[1] = '{4'b1001, 8'h20, 2'd0, 2'd1};
    rows[2] = '{4'b0110, 8'h30, 2'd1, 2'd2};
    rows[3] = '{4'b0011, 8'h40, 2'd0, 2'd1};
    rows[4] = '{4'b1111, 8'h50, 2'd1, 2'd2};
    rows[5] = '{4'b1000, 8'h60, 2'd3, 2'd0};
    rows[6] = '{4'b0100, 8'h70, 2'd2, 2'd3};

    rst = 1'b1; req = '0; req_data = '0; req_last = '0;
    model_en = 1'b0; man_done = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_trmt", {31'd0, trmt}, 32'd0);
    chk("reset_ack", {28'd0, ack}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_grant_id", {30'd0, grant_id}, 32'd0);
    chk("reset_tx_data", {24'd0, tx_data}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single request from requester 2, slow transmitter
    req = 4'b0100; req_data = 32'h00A5_0000;
    expect_grant(2'd2, 8'hA5);
    @(negedge clk);
    chk("single_trmt", {31'd0, trmt}, 32'd1);
    chk("single_ack", {28'd0, ack}, 32'h4);
    chk("single_busy", {31'd0, busy}, 32'd1);
    req = '0; man_done = 1'b0;
    repeat (10) @(negedge clk);
    chk("single_wait_busy", {31'd0, busy}, 32'd1);
    man_done = 1'b1;
    @(negedge clk);
    chk("single_idle", {31'd0, busy}, 32'd0);
    chk("single_rr_ptr", {30'd0, dut.rr_ptr}, 32'd3);

    // Table-driven arbitration rows, first row exercises the wrap from rr_ptr=3
    model_en = 1'b1;
    for (int r = 0; r < 7; r++) begin
      @(negedge clk);
      req = rows[r].req;
      for (int i = 0; i < 4; i++) req_data[8*i +: 8] = 8'(rows[r].base + 8'(i));
      expect_grant(rows[r].exp_id, 8'(rows[r].base + 8'(rows[r].exp_id)));
      @(negedge clk);
      chk($sformatf("row%0d_trmt", r), {31'd0, trmt}, 32'd1);
      req = '0;
      wait_idle(40, $sformatf("row%0d_idle", r));
      chk($sformatf("row%0d_rr_ptr", r), {30'd0, dut.rr_ptr}, {30'd0, rows[r].exp_ptr});
    end

    // Guard: tx_done still high in first BUSY cycle must not complete the byte
    model_en = 1'b0; man_done = 1'b1;
    @(negedge clk);
    req = 4'b0001; req_data = 32'h0000_003C;
    expect_grant(2'd0, 8'h3C);
    @(negedge clk);
    chk("guard_trmt", {31'd0, trmt}, 32'd1);
    req = '0;
    @(negedge clk);
    man_done = 1'b0;
    @(negedge clk);
    chk("guard_hold_busy", {31'd0, busy}, 32'd1);
    repeat (2) @(negedge clk);
    chk("guard_still_busy", {31'd0, busy}, 32'd1);
    man_done = 1'b1;
    @(negedge clk);
    chk("guard_release", {31'd0, busy}, 32'd0);

    // Reset while a byte is in flight
    @(negedge clk);
    req = 4'b0010; req_data = 32'h0000_5A00;
    expect_grant(2'd1, 8'h5A);
    @(negedge clk);
    chk("rstmid_trmt", {31'd0, trmt}, 32'd1);
    man_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid_trmt0", {31'd0, trmt}, 32'd0);
    chk("rstmid_ack0", {28'd0, ack}, 32'd0);
    chk("rstmid_busy0", {31'd0, busy}, 32'd0);
    chk("rstmid_grant0", {30'd0, grant_id}, 32'd0);
    chk("rstmid_txdata0", {24'd0, tx_data}, 32'd0);
    chk("rstmid_rr_ptr0", {30'd0, dut.rr_ptr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (trmt !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    chk("rstmid_wait_tx_done", {31'd0, bad}, 32'd0);
    man_done = 1'b1;
    expect_grant(2'd1, 8'h5A);
    @(negedge clk);
    chk("rstmid_regrant", {31'd0, trmt}, 32'd1);
    req = '0;
    wait_idle(20, "rstmid_idle");

    // Fairness: all four requesting continuously from rr_ptr=0
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_en = 1'b1;
    req_data = 32'h4342_4140;
    expect_grant(2'd0, 8'h40);
    expect_grant(2'd1, 8'h41);
    expect_grant(2'd2, 8'h42);
    expect_grant(2'd3, 8'h43);
    expect_grant(2'd0, 8'h40);
    req = 4'b1111;
    tcount = 0; n = 0;
    for (int i = 0; i < 4; i++) ackcnt[i] = 0;
    while (tcount < 5 && n < 200) begin
      @(negedge clk);
      n++;
      for (int i = 0; i < 4; i++) if (ack[i]) ackcnt[i]++;
      if (trmt) begin
        tt[tcount] = cyc;
        tcount++;
        if (tcount == 5) req = '0;
      end
    end
    chk("fair_trmt_count", tcount, 32'd5);
    chk("fair_ack0", ackcnt[0], 32'd2);
    chk("fair_ack1", ackcnt[1], 32'd1);
    chk("fair_ack2", ackcnt[2], 32'd1);
    chk("fair_ack3", ackcnt[3], 32'd1);
    for (int k = 1; k < tcount; k++) chk($sformatf("fair_spacing%0d", k), tt[k] - tt[k-1], L + 3);
    wait_idle(40, "fair_idle");

    // Packet of three bytes from requester 1 with requester 0 competing
`ifdef UART_TX_ARB_PKT_LOCK_EN
    expect_grant(2'd1, 8'hB0);
    expect_grant(2'd1, 8'hB1);
    expect_grant(2'd1, 8'hB2);
    expect_grant(2'd0, 8'hC0);
    expect_grant(2'd0, 8'hC1);
`else
    expect_grant(2'd1, 8'hB0);
    expect_grant(2'd0, 8'hC0);
    expect_grant(2'd1, 8'hB1);
    expect_grant(2'd0, 8'hC1);
    expect_grant(2'd1, 8'hB2);
`endif
    @(negedge clk);
    i0 = 0; i1 = 0; n = 0;
    req_data = 32'h0000_B0C0;
    req_last = 4'b0001;
    req = 4'b0010;
    while (!(i0 == 2 && i1 == 3 && busy == 1'b0) && n < 300) begin
      @(negedge clk);
      n++;
      if (ack[1]) begin
        i1++;
        if (i1 == 1) req[0] = 1'b1;
        if (i1 == 3) req[1] = 1'b0;
        else begin
          req_data[15:8] = 8'(8'hB0 + i1);
          req_last[1] = (i1 == 2);
        end
      end
      if (ack[0]) begin
        i0++;
        if (i0 == 2) req[0] = 1'b0;
        else req_data[7:0] = 8'(8'hC0 + i0);
      end
    end
    chk("pkt_complete", {31'd0, (i0 == 2 && i1 == 3)}, 32'd1);
    chk("sb_empty", sbq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
